sha256_compress_iter: RTL

Iterative SHA-256 compression core that runs all 64 rounds of one 512-bit block. It expands the message schedule internally from a 16-word sliding window. It adds the chaining value to produce a 256-bit digest. Successor to the half-block round engine in the bitcoin miner:
- Parametrised round unrolling.
- Valid/ready handshakes on both sides.
- Built-in final H addition.

---
 rtl/sha256_pkg.sv | 52 +++++
 rtl/sha256_round_step.sv | 17 +
 rtl/sha256_compress_iter.sv | 114 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants, widths, FSM encoding and round functions.
package sha256_pkg;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 512;
    localparam int HASH_W  = 256;

    typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

    localparam logic [HASH_W-1:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [WORD_W-1:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] ep0(input logic [WORD_W-1:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_W-1:0] ep1(input logic [WORD_W-1:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [WORD_W-1:0] ch(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y, input logic [WORD_W-1:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [WORD_W-1:0] maj(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y, input logic [WORD_W-1:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction
endpackage

// File: rtl/sha256_round_step.sv
// sha256_round_step: one combinational SHA-256 round plus one message-window shift; st[0]=a .. st[7]=h, w[0]=W[r].
module sha256_round_step
    import sha256_pkg::*;
(
    input  logic [5:0]              r,
    input  logic [7:0][WORD_W-1:0]  st,
    input  logic [15:0][WORD_W-1:0] w,
    output logic [7:0][WORD_W-1:0]  st_n,
    output logic [15:0][WORD_W-1:0] w_n
);
    logic [WORD_W-1:0] t1, t2;

    assign t1   = st[7] + ep1(st[4]) + ch(st[4], st[5], st[6]) + K[r] + w[0];
    assign t2   = ep0(st[0]) + maj(st[0], st[1], st[2]);
    assign st_n = {st[6:4], st[3] + t1, st[2:0], t1 + t2};
    assign w_n  = {sig1(w[14]) + w[9] + sig0(w[1]) + w[0], w[15:1]};
endmodule

// File: rtl/sha256_compress_iter.sv
// sha256_compress_iter: iterative 64-round SHA-256 compression with final H addition; SHA_ZERO_CHECK_EN adds out_hit.
module sha256_compress_iter
    import sha256_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_block,
    input  logic [HASH_W-1:0]  in_hash,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [HASH_W-1:0]  out_digest,
    output logic               busy
`ifdef SHA_ZERO_CHECK_EN
    ,
    output logic               out_hit
`endif
);
    state_t state, state_n;
    logic [5:0] round;
    logic [7:0][WORD_W-1:0] st, hcopy;
    logic [15:0][WORD_W-1:0] w;
    logic [7:0][WORD_W-1:0] st_c [UNROLL+1];
    logic [15:0][WORD_W-1:0] w_c [UNROLL+1];
    logic [HASH_W-1:0] sum;
    logic last;

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("UNROLL must be 1, 2, 4 or 8");
    end

    assign st_c[0] = st;
    assign w_c[0]  = w;
    for (genvar j = 0; j < UNROLL; j++) begin : g_step
        sha256_round_step u_step (
            .r   (round + 6'(j)),
            .st  (st_c[j]),
            .w   (w_c[j]),
            .st_n(st_c[j+1]),
            .w_n (w_c[j+1])
        );
    end

    assign last     = ({1'b0, round} + 7'(UNROLL)) == 7'd64;
    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;

    // chaining value plus final working state, word 0 in the top bits
    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) sum[HASH_W-1-WORD_W*i -: WORD_W] = hcopy[i] + st[i];
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_valid ? RUN : IDLE;
            RUN:     state_n = last ? FINAL : RUN;
            FINAL:   state_n = DONE;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    // datapath: load on accept, run rounds, register digest, hold until consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            round      <= '0;
            st         <= '0;
            w          <= '0;
            hcopy      <= '0;
            out_valid  <= 1'b0;
            out_digest <= '0;
`ifdef SHA_ZERO_CHECK_EN
            out_hit    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    for (int i = 0; i < 8; i++) begin
                        st[i]    <= in_hash[HASH_W-1-WORD_W*i -: WORD_W];
                        hcopy[i] <= in_hash[HASH_W-1-WORD_W*i -: WORD_W];
                    end
                    for (int i = 0; i < 16; i++) w[i] <= in_block[BLOCK_W-1-WORD_W*i -: WORD_W];
                    round <= '0;
                end
                RUN: begin
                    st    <= st_c[UNROLL];
                    w     <= w_c[UNROLL];
                    round <= round + 6'(UNROLL);
                end
                FINAL: begin
                    out_digest <= sum;
                    out_valid  <= 1'b1;
`ifdef SHA_ZERO_CHECK_EN
                    out_hit    <= sum[WORD_W-1:0] == '0;
`endif
                end
                DONE: if (out_ready) out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
